// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage stall/flush bundle and the hard-wired zero register index.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } ctrlState_t;

   typedef struct packed {
      logic stallF;
      logic stallD;
      logic stallE;
      logic stallM;
      logic flushD;
      logic flushE;
      logic flushM;
      logic flushW;
   } stallFlush_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory waits,
// multi-cycle mult/div, taken branches and load-use hazards into stage enables.
//
// state    | meaning
// RUN      | normal flow; branch flush and load-use stall evaluated here
// MD_BUSY  | mult/div occupying Execute, F/D held, bubble into M
// MEM_WAIT | data memory outstanding, F/D/E/M held, bubble into W
// ERR      | memory timed out; F/D/E/M held until reset
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int MD_LATENCY  = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             isloadE,
   input  logic [4:0]       rdE,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic             isbranchtakenE,
   input  logic             memreqM,
   input  logic             memreadyM,
   input  logic             mdstartE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             mddoneE,
   output logic             memerr,
   output logic [CNT_W-1:0] stallcount,
   output logic [CNT_W-1:0] flushcount
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int MD_W   = $clog2(MD_LATENCY);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [MD_W-1:0]   MD_LOAD   = MD_W'(MD_LATENCY - 1);

   localparam stallFlush_t CTL_MEM = 8'b1111_0001;
   localparam stallFlush_t CTL_MD  = 8'b1100_0010;
   localparam stallFlush_t CTL_BR  = 8'b0000_1100;
   localparam stallFlush_t CTL_LU  = 8'b1100_0100;
   localparam stallFlush_t CTL_ERR = 8'b1111_0000;

   ctrlState_t        state, stateNext, effState;
   logic [WAIT_W-1:0] waitCnt, waitNext;
   logic [MD_W-1:0]   mdCnt, mdNext;
   stallFlush_t       ctl;
   logic              memStall, loadUse, mdDone;
   logic              stallAny, flushAny;

   assign memStall = memreqM && !memreadyM;
   assign loadUse  = isloadE && (rdE != REG_ZERO) && ((rdE == rs1D) || (rdE == rs2D));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         waitCnt <= '0;
         mdCnt   <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitNext;
         mdCnt   <= mdNext;
      end
   end

   always_comb begin
      stateNext = state;
      waitNext  = waitCnt;
      mdNext    = mdCnt;
      ctl       = '0;
      mdDone    = 1'b0;
      effState  = state;
      // The cycle memory completes is treated as the state we resume into, so a
      // frozen mult/div counts it and RUN hazards are not lost.
      if ((state == MEM_WAIT) && memreadyM) begin
         effState  = (mdCnt != '0) ? MD_BUSY : RUN;
         stateNext = effState;
         waitNext  = '0;
      end
      case (effState)
         RUN: begin
            if (memStall) begin
               ctl       = CTL_MEM;
               stateNext = MEM_WAIT;
               waitNext  = WAIT_W'(1);
            end else if (mdstartE) begin
               ctl       = CTL_MD;
               mdNext    = MD_LOAD;
               stateNext = MD_BUSY;
            end else if (isbranchtakenE) begin
               ctl = CTL_BR;
            end else if (loadUse) begin
               ctl = CTL_LU;
            end
         end
         MD_BUSY: begin
            if (memStall) begin
               ctl       = CTL_MEM;
               stateNext = MEM_WAIT;
               waitNext  = WAIT_W'(1);
            end else begin
               ctl = CTL_MD;
               if (mdCnt == MD_W'(1)) begin
                  mdDone    = 1'b1;
                  mdNext    = '0;
                  stateNext = RUN;
               end else begin
                  mdNext    = mdCnt - MD_W'(1);
                  stateNext = MD_BUSY;
               end
            end
         end
         MEM_WAIT: begin
            ctl = CTL_MEM;
            if (waitCnt == WAIT_LAST) begin
               stateNext = ERR;
               waitNext  = '0;
            end else begin
               waitNext = waitCnt + WAIT_W'(1);
            end
         end
         ERR: begin
            ctl = CTL_ERR;
         end
      endcase
   end

   assign stallF  = ctl.stallF;
   assign stallD  = ctl.stallD;
   assign stallE  = ctl.stallE;
   assign stallM  = ctl.stallM;
   assign flushD  = ctl.flushD;
   assign flushE  = ctl.flushE;
   assign flushM  = ctl.flushM;
   assign flushW  = ctl.flushW;
   assign mddoneE = mdDone;
   assign memerr  = (state == ERR);

   assign stallAny = ctl.stallF | ctl.stallD | ctl.stallE | ctl.stallM;
   assign flushAny = ctl.flushD | ctl.flushE;

   sat_counter #(.CNT_W(CNT_W)) uStallCnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (stallAny),
      .count (stallcount)
   );

   sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (flushAny),
      .count (flushcount)
   );

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: stimulus queues the hand-derived
// per-cycle response, a negedge monitor pops and compares it.
module tb_pipeline_controller;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   localparam logic [7:0] NONE = 8'b0000_0000;
   localparam logic [7:0] LU   = 8'b1100_0100;
   localparam logic [7:0] BR   = 8'b0000_1100;
   localparam logic [7:0] MD   = 8'b1100_0010;
   localparam logic [7:0] MW   = 8'b1111_0001;
   localparam logic [7:0] ER   = 8'b1111_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          isloadE, isbranchtakenE, memreqM, memreadyM, mdstartE;
   logic [4:0]    rdE, rs1D, rs2D;
   logic          stallF, stallD, stallE, stallM;
   logic          flushD, flushE, flushM, flushW;
   logic          mddoneE, memerr;
   logic [CW-1:0] stallcount, flushcount;

   always #5 clk = ~clk;

   pipeline_controller #(.MEM_TIMEOUT(64), .MD_LATENCY(8), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .isloadE        (isloadE),
      .rdE            (rdE),
      .rs1D           (rs1D),
      .rs2D           (rs2D),
      .isbranchtakenE (isbranchtakenE),
      .memreqM        (memreqM),
      .memreadyM      (memreadyM),
      .mdstartE       (mdstartE),
      .stallF         (stallF),
      .stallD         (stallD),
      .stallE         (stallE),
      .stallM         (stallM),
      .flushD         (flushD),
      .flushE         (flushE),
      .flushM         (flushM),
      .flushW         (flushW),
      .mddoneE        (mddoneE),
      .memerr         (memerr),
      .stallcount     (stallcount),
      .flushcount     (flushcount)
   );

   typedef struct {
      string         name;
      logic [7:0]    ctl;
      logic          done;
      logic          err;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   mSc = 0;
   int   mFc = 0;

   task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got=%0h expected=%0h at %0t", nm, field, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t r;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            r = q.pop_front();
            chk(r.name, "ctl", 32'({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}), 32'(r.ctl));
            chk(r.name, "mddoneE", 32'(mddoneE), 32'(r.done));
            chk(r.name, "memerr", 32'(memerr), 32'(r.err));
            chk(r.name, "stallcount", 32'(stallcount), 32'(r.sc));
            chk(r.name, "flushcount", 32'(flushcount), 32'(r.fc));
         end
      end
   end

   task automatic setIn(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic br, input logic mreq, input logic mrdy, input logic mds);
      isloadE        = ld;
      rdE            = rd;
      rs1D           = r1;
      rs2D           = r2;
      isbranchtakenE = br;
      memreqM        = mreq;
      memreadyM      = mrdy;
      mdstartE       = mds;
   endtask

   task automatic idle();
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Queue this cycle's expected response, then advance the counter model.
   task automatic cyc(input string nm, input logic [7:0] e, input logic d, input logic er);
      exp_t r;
      r.name = nm;
      r.ctl  = e;
      r.done = d;
      r.err  = er;
      r.sc   = CW'(mSc);
      r.fc   = CW'(mFc);
      q.push_back(r);
      if (rst) begin
         mSc = 0;
         mFc = 0;
      end else begin
         if ((|e[7:4]) && (mSc < SAT)) mSc++;
         if ((e[3] | e[2]) && (mFc < SAT)) mFc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rstCyc(input string nm, input logic [7:0] e, input logic er);
      rst = 1'b1;
      cyc(nm, e, 1'b0, er);
      rst = 1'b0;
   endtask

   initial begin : stimulus
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      cyc("reset_idle", NONE, 1'b0, 1'b0);

      // load-use hazards
      setIn(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_rs1", LU, 1'b0, 1'b0);
      idle();
      cyc("lu_after", NONE, 1'b0, 1'b0);
      setIn(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_rs2", LU, 1'b0, 1'b0);
      setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_r0", NONE, 1'b0, 1'b0);
      setIn(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_noload", NONE, 1'b0, 1'b0);
      setIn(1'b1, 5'd9, 5'd4, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("lu_nomatch", NONE, 1'b0, 1'b0);

      // branch beats load-use
      setIn(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("br_lu", BR, 1'b0, 1'b0);
      idle();
      cyc("br_after", NONE, 1'b0, 1'b0);

      // mult/div: 8 stalled cycles, done on the 8th; mdstartE/branch ignored while busy
      rstCyc("rst1", NONE, 1'b0);
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("md_start", MD, 1'b0, 1'b0);
      idle();
      cyc("md_busy", MD, 1'b0, 1'b0);
      mdstartE = 1'b1;
      cyc("md_busy_restart", MD, 1'b0, 1'b0);
      mdstartE = 1'b0;
      isbranchtakenE = 1'b1;
      cyc("md_busy_br", MD, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) cyc("md_busy", MD, 1'b0, 1'b0);
      cyc("md_done", MD, 1'b1, 1'b0);
      cyc("md_after", NONE, 1'b0, 1'b0);

      // memory wait 5 cycles, released when ready
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc("mem_wait", MW, 1'b0, 1'b0);
      memreadyM = 1'b1;
      cyc("mem_release", NONE, 1'b0, 1'b0);
      cyc("mem_same_cycle", NONE, 1'b0, 1'b0);
      idle();
      cyc("mem_after", NONE, 1'b0, 1'b0);

      // memory wait inside mult/div: done lands 4 cycles late
      rstCyc("rst2", NONE, 1'b0);
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("mdm_start", MD, 1'b0, 1'b0);
      idle();
      cyc("mdm_busy", MD, 1'b0, 1'b0);
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc("mdm_memwait", MW, 1'b0, 1'b0);
      memreadyM = 1'b1;
      cyc("mdm_resume", MD, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 4; i++) cyc("mdm_busy2", MD, 1'b0, 1'b0);
      cyc("mdm_done", MD, 1'b1, 1'b0);
      cyc("mdm_after", NONE, 1'b0, 1'b0);

      // reset aborts mult/div with no done pulse, and leaves no pending op
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("mda_start", MD, 1'b0, 1'b0);
      idle();
      cyc("mda_busy", MD, 1'b0, 1'b0);
      cyc("mda_busy", MD, 1'b0, 1'b0);
      rstCyc("mda_rst", MD, 1'b0);
      for (int i = 0; i < 8; i++) cyc("mda_nodone", NONE, 1'b0, 1'b0);
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("mda_mem", MW, 1'b0, 1'b0);
      memreadyM = 1'b1;
      cyc("mda_mem_exit", NONE, 1'b0, 1'b0);
      idle();
      cyc("mda_after", NONE, 1'b0, 1'b0);

      // 63 wait cycles is just under the timeout
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 63; i++) cyc("mem_w63", MW, 1'b0, 1'b0);
      memreadyM = 1'b1;
      cyc("mem_w63_exit", NONE, 1'b0, 1'b0);

      // 64 wait cycles times out; ERR holds until reset, counter saturates
      setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) cyc("mem_w64", MW, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("err_hold", ER, 1'b0, 1'b1);
      memreadyM = 1'b1;
      cyc("err_ready", ER, 1'b0, 1'b1);
      idle();
      rstCyc("err_rst", ER, 1'b1);
      cyc("post_rst", NONE, 1'b0, 1'b0);
      cyc("post_rst2", NONE, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches hazard sources from Decode, Execute and Memory (load-use, taken branch, slow data memory, multi-cycle multiply/divide) and drives per-stage stall and flush enables into the Fetch/Decode/Execute/Memory/Writeback pipeline registers. It also keeps saturating stall/flush performance counters. It sits beside the forwarding unit and does not change operand selection.

## Interface
- MEM_TIMEOUT, default 64: max consecutive memory-wait cycles before `memerr` sets.
- MD_LATENCY, default 8: cycles a mult/div op occupies Execute (≥2).
- CNT_W, default 32: performance counter width.

- clk  in  1  pipeline clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- isloadE  in  1  instruction in E is a load.
- rdE  in  5  destination register of E.
- rs1D, rs2D  in  5  source registers of D.
- isbranchtakenE  in  1  branch/jump resolved taken in E.
- memreqM  in  1  M performs a data-memory read or write.
- memreadyM  in  1  data memory completes the access this cycle.
- mdstartE  in  1  mult/div instruction enters E (sampled only in RUN).
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register.
- flushD, flushE, flushM, flushW  out  1  load a bubble (all controls zero) into the corresponding register.
- mddoneE  out  1  one-cycle pulse on the final mult/div cycle.
- memerr  out  1  sticky memory-timeout flag.
- stallcount, flushcount  out  CNT_W  saturating event counters.

## Operation
- States: RUN, MD_BUSY, MEM_WAIT, ERR.
- Priority each cycle, highest first: MEM_WAIT, then MD_BUSY, then branch flush, then load-use.
- RUN, memreqM && !memreadyM:
  - go to MEM_WAIT.
  - Assert stallF/D/E/M and flushW in this same cycle; output is Mealy.
- MEM_WAIT:
  - Hold the same outputs. Wait counter increments each cycle.
  - memreadyM returns to RUN; outputs deassert in that cycle.
  - Counter reaching MEM_TIMEOUT goes to ERR and sets memerr.
- ERR: stallF/D/E/M held high permanently; only rst exits.
- RUN, mdstartE:
  - Load md counter with MD_LATENCY-1 and go to MD_BUSY.
  - Assert stallF/D and flushM on entry and each busy cycle.
  - When the counter reaches 0, pulse mddoneE, deassert stalls, return to RUN.
  - If memreqM && !memreadyM arrives during MD_BUSY, MEM_WAIT stalls override. The md counter freezes and resumes after.
- RUN, isbranchtakenE: flushD and flushE for one cycle. Load-use is ignored in that cycle because the D instruction is squashed.
- RUN, load-use (isloadE && rdE!=0 && (rdE==rs1D || rdE==rs2D)): stallF, stallD, flushE for exactly one cycle.
- rdE == 0 never causes a load-use stall.
- stallcount +1 for every cycle in which any stall output is high.
- flushcount +1 for every cycle in which flushD or flushE is high.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset: state RUN; all stall/flush outputs 0; mddoneE 0; memerr 0; both counters 0; wait and md counters 0.
- rst asserted mid-MEM_WAIT or mid-MD_BUSY aborts the operation at the next edge. No mddoneE is emitted.
- Detection-to-output latency is 0 cycles (Mealy). State changes at the next rising edge.
- A mult/div op stalls F/D for exactly MD_LATENCY cycles, counting the start cycle. mddoneE occurs in the last of these cycles.
- memreadyM arriving in the same cycle as memreqM causes no stall.
- The wait counter clears on every MEM_WAIT exit.

## Structure
- pipeline_ctrl_pkg holds:
  - the state enum (RUN, MD_BUSY, MEM_WAIT, ERR);
  - the stall/flush bundle struct;
  - the register-zero constant.
- Sub-module sat_counter (parameter CNT_W, inputs inc and clr): used twice, for stallcount and flushcount.
- Load-use compare is inline combinational logic.

## Test plan
- Load `lw $5` in E, D reads rs1=5 → stallF=stallD=flushE=1 for 1 cycle; stallcount=1. Repeat with rdE=0 → no stall.
- isbranchtakenE=1 together with a load-use match → flushD=flushE=1, no stalls; flushcount=1.
- mdstartE with MD_LATENCY=8 → stallF/D and flushM high 8 cycles; mddoneE pulses on cycle 8; stallcount=8.
- memreqM=1, memreadyM low 5 cycles → stallF/D/E/M and flushW high 5 cycles; released on cycle 6 when ready=1.
- memreadyM held low for 64 cycles → memerr=1 and stalls stay high; rst → all outputs 0.
- MEM_WAIT starting at cycle 3 of MD_BUSY for 4 cycles → md op completes 4 cycles late; mddoneE still pulses once.
